// File: rtl/disp_pkg.sv
// Shared types, default configuration and helper functions for the scrolling
// display driver. Optional brightness dimming is enabled with DISPLAY_DIM_EN.
package disp_pkg;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_CHAR_W       = 4;
  localparam int DEF_MSG_DEPTH    = 16;
  localparam int DEF_SLOT_CYCLES  = 4;
  localparam int DEF_GUARD_CYCLES = 2;
  localparam int DEF_SCROLL_DIV_W = 10;

  typedef logic [DEF_CHAR_W-1:0] char_t;

  // Address width that stays legal for a single-entry message RAM.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One scroll step modulo the message depth, wrapping in either direction.
  function automatic int unsigned step_mod(input int unsigned cur, input logic dir,
                                           input int unsigned depth);
    if (dir) begin
      return (cur == 0) ? depth - 1 : cur - 1;
    end else begin
      return (cur == depth - 1) ? 0 : cur + 1;
    end
  endfunction

  localparam int ACTIVE_CYCLES = DEF_SLOT_CYCLES - 1 - DEF_GUARD_CYCLES;
  localparam int FRAME_CYCLES  = DEF_NUM_DIGITS * DEF_SLOT_CYCLES;
  localparam int ADDR_W        = addr_bits(DEF_MSG_DEPTH);

endpackage

// File: rtl/scroll_display_driver_base.sv
// Scroll divider and message base pointer: ticks accumulate in a pending base
// which is committed only on a frame boundary so no frame mixes two bases.
module scroll_base_ctrl
  import disp_pkg::*;
#(
  parameter int MSG_DEPTH    = DEF_MSG_DEPTH,
  parameter int SCROLL_DIV_W = DEF_SCROLL_DIV_W,
  parameter int AW           = addr_bits(DEF_MSG_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scroll_en,
  input  logic          scroll_dir,
  input  logic          boundary,
  output logic [AW-1:0] cur_base
);

  logic [SCROLL_DIV_W-1:0] div_r;
  logic [AW-1:0]           pend_r;
  logic [AW-1:0]           base_r;
  logic                    tick_s;
  logic [AW-1:0]           pend_nxt_s;

  // Tick on the divider wrap; a tick coinciding with a frame boundary is seen by that frame.
  always_comb begin
    tick_s = scroll_en && (&div_r);
    if (tick_s) begin
      pend_nxt_s = AW'(step_mod(int'(pend_r), scroll_dir, MSG_DEPTH));
    end else begin
      pend_nxt_s = pend_r;
    end
    cur_base = boundary ? pend_nxt_s : base_r;
  end

  // Divider, pending base and committed base registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r  <= '0;
      pend_r <= '0;
      base_r <= '0;
    end else begin
      if (scroll_en) begin
        div_r <= div_r + SCROLL_DIV_W'(1);
      end
      pend_r <= pend_nxt_s;
      if (boundary) begin
        base_r <= pend_nxt_s;
      end
    end
  end

endmodule

// File: rtl/scroll_display_driver.sv
// Multiplexed 7-seg anode/character driver with a writable scrolling message RAM.
// Define DISPLAY_DIM_EN to add the dim input that shortens the lit window.
module scroll_display_driver
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int CHAR_W       = DEF_CHAR_W,
  parameter int MSG_DEPTH    = DEF_MSG_DEPTH,
  parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int SCROLL_DIV_W = DEF_SCROLL_DIV_W
) (
  input  logic                            clk,
  input  logic                            SYNC_DEBNC_RST,
  input  logic                            scroll_en,
  input  logic                            scroll_dir,
  input  logic                            wr_en,
  input  logic [addr_bits(MSG_DEPTH)-1:0] wr_addr,
  input  logic [CHAR_W-1:0]               wr_data,
`ifdef DISPLAY_DIM_EN
  input  logic [$clog2(SLOT_CYCLES):0]    dim,
`endif
  output logic [NUM_DIGITS-1:0]           an,
  output logic [CHAR_W-1:0]               char,
  output logic                            frame_start
);

  localparam int ACT_LEN = SLOT_CYCLES - 1 - GUARD_CYCLES;
  localparam int AW      = addr_bits(MSG_DEPTH);
  localparam int AW1     = AW + 1;
  localparam int KW      = $clog2(SLOT_CYCLES);
  localparam int DW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [KW-1:0]         k_r;
  logic [DW-1:0]         dig_r;
  logic [CHAR_W-1:0]     msg_r [MSG_DEPTH];
  logic [NUM_DIGITS-1:0] an_r;
  logic [CHAR_W-1:0]     char_r;
  logic                  fs_r;
  logic                  boundary_s;
  logic                  lit_s;
  logic [AW-1:0]         cur_base_s;
  logic [AW:0]           addr_sum_s;
  logic [AW-1:0]         rd_addr_s;
`ifdef DISPLAY_DIM_EN
  logic [KW:0]           dim_r;
`endif

  scroll_base_ctrl #(
    .MSG_DEPTH    (MSG_DEPTH),
    .SCROLL_DIV_W (SCROLL_DIV_W),
    .AW           (AW)
  ) u_base (
    .clk        (clk),
    .rst        (SYNC_DEBNC_RST),
    .scroll_en  (scroll_en),
    .scroll_dir (scroll_dir),
    .boundary   (boundary_s),
    .cur_base   (cur_base_s)
  );

  // Slot decode and message read address (base+digit folded back into range).
  always_comb begin
    boundary_s = (k_r == KW'(0)) && (dig_r == DW'(NUM_DIGITS - 1));
    lit_s      = (k_r != KW'(0)) && (k_r <= KW'(ACT_LEN));
`ifdef DISPLAY_DIM_EN
    lit_s      = lit_s && ({1'b0, k_r} <= dim_r);
`endif
    addr_sum_s = {1'b0, cur_base_s} + AW1'(dig_r);
    if (addr_sum_s >= AW1'(MSG_DEPTH)) begin
      rd_addr_s = AW'(addr_sum_s - AW1'(MSG_DEPTH));
    end else begin
      rd_addr_s = AW'(addr_sum_s);
    end
  end

  // Slot sequencer and registered display outputs; char only changes while all anodes are off.
  always_ff @(posedge clk or posedge SYNC_DEBNC_RST) begin
    if (SYNC_DEBNC_RST) begin
      k_r    <= '0;
      dig_r  <= DW'(NUM_DIGITS - 1);
      an_r   <= {NUM_DIGITS{1'b1}};
      char_r <= '0;
      fs_r   <= 1'b0;
`ifdef DISPLAY_DIM_EN
      dim_r  <= '0;
`endif
    end else begin
      if (k_r == KW'(SLOT_CYCLES - 1)) begin
        k_r   <= '0;
        dig_r <= (dig_r == DW'(0)) ? DW'(NUM_DIGITS - 1) : dig_r - DW'(1);
      end else begin
        k_r <= k_r + KW'(1);
      end
      if (k_r == KW'(0)) begin
        char_r <= msg_r[rd_addr_s];
`ifdef DISPLAY_DIM_EN
        dim_r  <= dim;
`endif
      end
      an_r <= lit_s ? ~(NUM_DIGITS'(1) << dig_r) : {NUM_DIGITS{1'b1}};
      fs_r <= boundary_s;
    end
  end

  // Message RAM; the read above samples the old contents on a same-cycle write.
  always_ff @(posedge clk or posedge SYNC_DEBNC_RST) begin
    if (SYNC_DEBNC_RST) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        msg_r[i] <= CHAR_W'(i);
      end
    end else begin
      if (wr_en && ({1'b0, wr_addr} < AW1'(MSG_DEPTH))) begin
        msg_r[wr_addr] <= wr_data;
      end
    end
  end

  assign an          = an_r;
  assign char        = char_r;
  assign frame_start = fs_r;

endmodule

// File: tb/tb_scroll_display_driver.sv
// Randomised scoreboard bench for scroll_display_driver against a frame-level reference model.
module tb_scroll_display_driver;

  localparam int ND  = 4;
  localparam int CW  = 4;
  localparam int MD  = 12;
  localparam int SC  = 4;
  localparam int GC  = 2;
  localparam int DVW = 3;
  localparam int AW  = 4;
  localparam int ACT = SC - 1 - GC;
  localparam int FR  = ND * SC;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          scroll_en = 1'b0;
  logic          scroll_dir = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic [ND-1:0] an;
  logic [CW-1:0] char;
  logic          frame_start;
`ifdef DISPLAY_DIM_EN
  logic [$clog2(SC):0] dim = '0;
`endif

  scroll_display_driver #(
    .NUM_DIGITS   (ND),
    .CHAR_W       (CW),
    .MSG_DEPTH    (MD),
    .SLOT_CYCLES  (SC),
    .GUARD_CYCLES (GC),
    .SCROLL_DIV_W (DVW)
  ) dut (
    .clk            (clk),
    .SYNC_DEBNC_RST (rst),
    .scroll_en      (scroll_en),
    .scroll_dir     (scroll_dir),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
`ifdef DISPLAY_DIM_EN
    .dim            (dim),
`endif
    .an             (an),
    .char           (char),
    .frame_start    (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ND-1:0] an;
    logic [CW-1:0] ch;
    logic          fs;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   total = 0;
  int   bad = 0;

  int msg [MD];
  int base, pend, divc, t, ech, dimv;

  task automatic model_reset();
    for (int i = 0; i < MD; i++) msg[i] = i % (1 << CW);
    base = 0; pend = 0; divc = 0; t = 0; ech = 0; dimv = ACT;
    last_exp.an = '1; last_exp.ch = '0; last_exp.fs = 1'b0;
    q.push_back(last_exp);
  endtask

  // Expected outputs for the coming edge, from the position of that edge in the frame.
  task automatic model_edge();
    int  k, slot, d;
    bit  tick, lit;
    exp_t e;
    k    = t % SC;
    slot = (t % FR) / SC;
    d    = ND - 1 - slot;
    tick = scroll_en && (divc == (1 << DVW) - 1);
    if (scroll_en) divc = (divc + 1) % (1 << DVW);
    if (tick) pend = scroll_dir ? (pend + MD - 1) % MD : (pend + 1) % MD;
    if (k == 0 && slot == 0) base = pend;
    if (k == 0) begin
      ech = msg[(base + d) % MD];
`ifdef DISPLAY_DIM_EN
      dimv = int'(dim);
`endif
    end
    lit  = (k >= 1) && (k <= ACT) && (k <= dimv);
    e.an = '1;
    if (lit) e.an[d] = 1'b0;
    e.ch = CW'(ech);
    e.fs = (k == 0) && (slot == 0);
    if (wr_en && int'(wr_addr) < MD) msg[wr_addr] = int'(wr_data);
    t++;
    last_exp = e;
    q.push_back(e);
  endtask

  // Monitor: one expectation per edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (an !== e.an || char !== e.ch || frame_start !== e.fs) begin
          bad++;
          $display("FAIL outputs @%0t: got an=%b char=%h fs=%b, want an=%b char=%h fs=%b",
                   $time, an, char, frame_start, e.an, e.ch, e.fs);
        end
      end
    end
  end

  initial begin
    int rst_cnt;
    bit mid_done;
    rst_cnt  = 3;
    mid_done = 1'b0;
    #1 rst = 1'b1;
    #1;
    total++;
    if (an !== 4'b1111 || char !== 4'h0 || frame_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got an=%b char=%h fs=%b, want an=1111 char=0 fs=0",
               an, char, frame_start);
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc % 300 == 0) scroll_dir = 1'($urandom % 2);
      scroll_en = ($urandom % 4) != 0;
      wr_en     = ($urandom % 6) == 0;
      wr_addr   = AW'($urandom % 16);
      wr_data   = CW'($urandom);
`ifdef DISPLAY_DIM_EN
      dim       = ($clog2(SC) + 1)'($urandom_range(0, SC));
`endif
      if (!mid_done && cyc > 2000 && rst_cnt == 0 && last_exp.an[1] === 1'b0) begin
        rst = 1'b1;
        #1;
        total++;
        if (an !== 4'b1111 || char !== 4'h0 || frame_start !== 1'b0) begin
          bad++;
          $display("FAIL async_reset: got an=%b char=%h fs=%b, want an=1111 char=0 fs=0",
                   an, char, frame_start);
        end
        mid_done = 1'b1;
        rst_cnt  = 3;
      end
      rst = (rst_cnt > 0);
      if (rst_cnt > 0) rst_cnt--;
      if (rst) begin
        model_reset();
      end else begin
        model_edge();
      end
    end
    @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
